// File: rtl/nco_clk_gen_if.sv
// IOb-native CSR bus between a system-bus master and the NCO clock generator.
// The slave answers every request at once (ready tied high) and returns read data one cycle later.
interface nco_clk_gen_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic                iob_valid;
    logic [ADDR_W-1:0]   iob_addr;
    logic [DATA_W-1:0]   iob_wdata;
    logic [DATA_W/8-1:0] iob_wstrb;
    logic [DATA_W-1:0]   iob_rdata;
    logic                iob_ready;
    logic                iob_rvalid;
    logic                iob_rready;

    modport master (
        output iob_valid, iob_addr, iob_wdata, iob_wstrb, iob_rready,
        input  iob_rdata, iob_ready, iob_rvalid
    );

    modport slave (
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb, iob_rready,
        output iob_rdata, iob_ready, iob_rvalid
    );
endinterface

// File: rtl/nco_clk_gen.sv
// Fractional-N clock generator: clk_out_o averages PERIOD_INT + PERIOD_FRAC/2^32 clk_i cycles
// per period, programmed through four byte-strobed CSRs.
module nco_clk_gen #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         cke_i,
    nco_clk_gen_if.slave bus,
    output logic         clk_out_o
);
    localparam logic [1:0] REG_SOFT_RESET  = 2'd0;
    localparam logic [1:0] REG_ENABLE      = 2'd1;
    localparam logic [1:0] REG_PERIOD_INT  = 2'd2;
    localparam logic [1:0] REG_PERIOD_FRAC = 2'd3;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        word_sel;
    logic              wr_req;
    logic              rd_req;
    logic              unused_addr;

    logic              soft_reg, soft_next;
    logic              enable_reg, enable_next;
    logic [DATA_W-1:0] int_reg, int_next;
    logic [DATA_W-1:0] frac_reg, frac_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next, rd_word;
    logic              rvalid_reg, rvalid_next;

    logic [32:0]       cnt_reg, cnt_next;
    logic [32:0]       p_reg, p_next;
    logic [31:0]       acc_reg, acc_next;
    logic              run_reg, run_next;
    logic              clk_out_reg, clk_out_next;

    logic [32:0]       acc_sum;
    logic              period_end;
    logic              engine_on;
    logic              engine_keep;

    assign addr        = bus.iob_addr;
    assign word_sel    = addr[3:2];
    assign unused_addr = ^addr[1:0];
    assign wr_req      = bus.iob_valid && (bus.iob_wstrb != '0);
    assign rd_req      = bus.iob_valid && (bus.iob_wstrb == '0);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
            assign int_next[8*gi +: 8]  = (wr_req && word_sel == REG_PERIOD_INT && bus.iob_wstrb[gi])
                                        ? bus.iob_wdata[8*gi +: 8] : int_reg[8*gi +: 8];
            assign frac_next[8*gi +: 8] = (wr_req && word_sel == REG_PERIOD_FRAC && bus.iob_wstrb[gi])
                                        ? bus.iob_wdata[8*gi +: 8] : frac_reg[8*gi +: 8];
        end
    endgenerate

    assign soft_next   = (wr_req && word_sel == REG_SOFT_RESET && bus.iob_wstrb[0]) ? bus.iob_wdata[0] : soft_reg;
    assign enable_next = (wr_req && word_sel == REG_ENABLE && bus.iob_wstrb[0]) ? bus.iob_wdata[0] : enable_reg;

    always_comb begin
        rd_word = '0;
        unique case (word_sel)
            REG_SOFT_RESET:  rd_word = {{(DATA_W-1){1'b0}}, soft_reg};
            REG_ENABLE:      rd_word = {{(DATA_W-1){1'b0}}, enable_reg};
            REG_PERIOD_INT:  rd_word = int_reg;
            REG_PERIOD_FRAC: rd_word = frac_reg;
        endcase
    end

    // A new read replaces the held response; otherwise rdata stays put until the master takes it.
    assign rdata_next  = rd_req ? rd_word : rdata_reg;
    assign rvalid_next = rd_req ? 1'b1 : (bus.iob_rready ? 1'b0 : rvalid_reg);

    assign acc_sum    = {1'b0, acc_reg} + {1'b0, frac_reg};
    // P of 0 or 1 closes the period every cycle so later CSR changes are still picked up.
    assign period_end = ({1'b0, cnt_reg} + 34'd1) >= {1'b0, p_reg};
    assign engine_on  = enable_reg && !soft_reg;
    // Clearing looks at the CSR values being written so the output drops the cycle after the write.
    assign engine_keep = enable_next && !soft_next;

    always_comb begin
        cnt_next     = cnt_reg;
        p_next       = p_reg;
        acc_next     = acc_reg;
        run_next     = run_reg;
        clk_out_next = clk_out_reg;
        if (!engine_keep) begin
            cnt_next     = '0;
            p_next       = '0;
            acc_next     = '0;
            run_next     = 1'b0;
            clk_out_next = 1'b0;
        end else if (engine_on) begin
            clk_out_next = run_reg && (cnt_reg < (p_reg >> 1));
            if (!run_reg || period_end) begin
                acc_next = acc_sum[31:0];
                p_next   = {1'b0, int_reg} + {32'd0, acc_sum[32]};
                cnt_next = '0;
                run_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 33'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            soft_reg    <= 1'b0;
            enable_reg  <= 1'b0;
            int_reg     <= '0;
            frac_reg    <= '0;
            rdata_reg   <= '0;
            rvalid_reg  <= 1'b0;
            cnt_reg     <= '0;
            p_reg       <= '0;
            acc_reg     <= '0;
            run_reg     <= 1'b0;
            clk_out_reg <= 1'b0;
        end else if (cke_i) begin
            soft_reg    <= soft_next;
            enable_reg  <= enable_next;
            int_reg     <= int_next;
            frac_reg    <= frac_next;
            rdata_reg   <= rdata_next;
            rvalid_reg  <= rvalid_next;
            cnt_reg     <= cnt_next;
            p_reg       <= p_next;
            acc_reg     <= acc_next;
            run_reg     <= run_next;
            clk_out_reg <= clk_out_next;
        end
    end

    assign bus.iob_ready  = 1'b1;
    assign bus.iob_rdata  = rdata_reg;
    assign bus.iob_rvalid = rvalid_reg;
    assign clk_out_o      = clk_out_reg;
endmodule

// File: tb/tb_nco_clk_gen.sv
// Bench for nco_clk_gen: CSR vector table, hand-built corner sequences and random period
// settings compared against a per-period arithmetic model of the output waveform.
`timescale 1ns/1ps
module tb_nco_clk_gen;
    logic clk = 1'b0;
    logic arst_n;
    logic cke;
    logic clk_out;

    always #5 clk = ~clk;

    nco_clk_gen_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    nco_clk_gen #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk_i     (clk),
        .arst_n_i  (arst_n),
        .cke_i     (cke),
        .bus       (bus),
        .clk_out_o (clk_out)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit exp_q[$];

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rd;
    } csr_vec_t;

    csr_vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic csr_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.iob_valid = 1'b1;
        bus.iob_addr  = addr;
        bus.iob_wdata = data;
        bus.iob_wstrb = strb;
        tick();
        bus.iob_valid = 1'b0;
        bus.iob_wstrb = 4'h0;
        $display("[TB] write addr=0x%h data=0x%h strb=%b", addr, data, strb);
    endtask

    task automatic csr_read(input logic [3:0] addr, output logic [31:0] data);
        bus.iob_valid = 1'b1;
        bus.iob_addr  = addr;
        bus.iob_wstrb = 4'h0;
        tick();
        bus.iob_valid = 1'b0;
        check("read_rvalid", {63'd0, bus.iob_rvalid}, 64'd1);
        data = bus.iob_rdata;
        bus.iob_rready = 1'b1;
        tick();
        bus.iob_rready = 1'b0;
        check("read_rvalid_clear", {63'd0, bus.iob_rvalid}, 64'd0);
        $display("[TB] read  addr=0x%h data=0x%h", addr, data);
    endtask

    task automatic push_period(input longint p);
        for (longint j = 0; j < p; j++) exp_q.push_back(j < p / 2);
    endtask

    // Period k length is INT plus the number of 2^32 wraps of k*FRAC between k and k+1.
    task automatic build_model(input longint unsigned int_v, input longint unsigned frac_v, input int n);
        longint unsigned k = 0;
        longint unsigned p;
        exp_q.delete();
        exp_q.push_back(1'b0);
        while (exp_q.size() < n) begin
            p = int_v + (((k + 1) * frac_v) >> 32) - ((k * frac_v) >> 32);
            if (p == 0) exp_q.push_back(1'b0);
            else push_period(longint'(p));
            k++;
        end
    endtask

    task automatic run_compare(input string name, input int n, input int wr_at,
                               input logic [3:0] wr_addr, input logic [31:0] wr_data, input int zero_from);
        int  errs  = 0;
        int  first = -1;
        bit  e;
        for (int i = 0; i < n; i++) begin
            if (i == wr_at) begin
                bus.iob_valid = 1'b1;
                bus.iob_addr  = wr_addr;
                bus.iob_wdata = wr_data;
                bus.iob_wstrb = 4'hF;
            end
            tick();
            bus.iob_valid = 1'b0;
            bus.iob_wstrb = 4'h0;
            e = (i >= zero_from) ? 1'b0 : exp_q[i];
            if (clk_out !== e) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        check(name, 64'(errs), 64'd0);
        $display("[TB] %s: %0d cycles compared, %0d wrong, first wrong cycle %0d", name, n, errs, first);
    endtask

    task automatic start_engine(input logic [31:0] int_v, input logic [31:0] frac_v);
        csr_write(4'h4, 32'h0, 4'hF);
        csr_write(4'h8, int_v, 4'hF);
        csr_write(4'hC, frac_v, 4'hF);
        csr_write(4'h4, 32'h1, 4'hF);
        check("start_low", {63'd0, clk_out}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rint, rfrac;

        vecs[0] = '{4'h8, 32'h0000_0012, 4'hF,    32'h0000_0012};
        vecs[1] = '{4'hC, 32'h8000_0000, 4'hF,    32'h8000_0000};
        vecs[2] = '{4'h8, 32'hAABB_CCDD, 4'b0101, 32'h00BB_00DD};
        vecs[3] = '{4'hC, 32'h1122_3344, 4'b1000, 32'h1100_0000};
        vecs[4] = '{4'h0, 32'hFFFF_FFFF, 4'hF,    32'h0000_0001};
        vecs[5] = '{4'h0, 32'h0000_0000, 4'b0010, 32'h0000_0001};
        vecs[6] = '{4'h0, 32'h0000_0000, 4'hF,    32'h0000_0000};
        vecs[7] = '{4'h4, 32'hFFFF_FFFE, 4'hF,    32'h0000_0000};
        vecs[8] = '{4'h9, 32'h0000_0012, 4'hF,    32'h0000_0012};
        vecs[9] = '{4'hD, 32'h8000_0000, 4'hF,    32'h8000_0000};

        arst_n         = 1'b0;
        cke            = 1'b1;
        bus.iob_valid  = 1'b0;
        bus.iob_addr   = 4'h0;
        bus.iob_wdata  = 32'h0;
        bus.iob_wstrb  = 4'h0;
        bus.iob_rready = 1'b0;
        repeat (3) tick();
        check("reset_clk_out", {63'd0, clk_out}, 64'd0);
        check("reset_rvalid", {63'd0, bus.iob_rvalid}, 64'd0);
        check("reset_rdata", {32'd0, bus.iob_rdata}, 64'd0);
        arst_n = 1'b1;
        tick();
        check("ready_high", {63'd0, bus.iob_ready}, 64'd1);
        for (int a = 0; a < 4; a++) begin
            csr_read(4'(a * 4), rd);
            check($sformatf("reset_csr%0d", a), {32'd0, rd}, 64'd0);
        end

        for (int v = 0; v < 10; v++) begin
            csr_write(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
            csr_read(vecs[v].addr, rd);
            check($sformatf("csr_vec%0d", v), {32'd0, rd}, {32'd0, vecs[v].exp_rd});
        end

        // Read response must hold while the master stalls.
        bus.iob_valid = 1'b1; bus.iob_addr = 4'h8; bus.iob_wstrb = 4'h0;
        tick();
        bus.iob_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hold_rvalid", {63'd0, bus.iob_rvalid}, 64'd1);
            check("hold_rdata", {32'd0, bus.iob_rdata}, 64'h12);
            tick();
        end
        bus.iob_rready = 1'b1;
        tick();
        check("hold_release", {63'd0, bus.iob_rvalid}, 64'd0);
        tick();
        bus.iob_rready = 1'b0;
        check("rready_idle", {63'd0, bus.iob_rvalid}, 64'd0);
        $display("[TB] stalled read of 0x8 held for 4 cycles");

        // Clock enable low must freeze the CSR path.
        cke = 1'b0;
        bus.iob_valid = 1'b1; bus.iob_addr = 4'h8; bus.iob_wdata = 32'h99; bus.iob_wstrb = 4'hF;
        repeat (2) tick();
        bus.iob_valid = 1'b0; bus.iob_wstrb = 4'h0;
        check("cke_rvalid_frozen", {63'd0, bus.iob_rvalid}, 64'd0);
        cke = 1'b1;
        csr_read(4'h8, rd);
        check("cke_write_blocked", {32'd0, rd}, 64'h12);

        // 18.5-cycle average: soft reset pulse first.
        csr_write(4'h0, 32'h1, 4'hF);
        csr_write(4'h0, 32'h0, 4'hF);
        start_engine(32'h12, 32'h8000_0000);
        build_model(64'h12, 64'h8000_0000, 160);
        run_compare("nco_18p5", 160, -1, 4'h0, 32'h0, 1 << 30);

        // Soft reset mid-run, while the output is high.
        csr_write(4'h0, 32'h1, 4'hF);
        csr_write(4'h0, 32'h0, 4'hF);
        check("soft_restart_low", {63'd0, clk_out}, 64'd0);
        build_model(64'h12, 64'h8000_0000, 20);
        run_compare("soft_mid_run", 20, 4, 4'h0, 32'h1, 4);
        csr_read(4'h8, rd);
        check("soft_keeps_int", {32'd0, rd}, 64'h12);
        csr_read(4'hC, rd);
        check("soft_keeps_frac", {32'd0, rd}, 64'h8000_0000);
        csr_read(4'h4, rd);
        check("soft_keeps_enable", {32'd0, rd}, 64'h1);
        check("soft_held_low", {63'd0, clk_out}, 64'd0);
        csr_write(4'h0, 32'h0, 4'hF);
        check("soft_release_low", {63'd0, clk_out}, 64'd0);
        build_model(64'h12, 64'h8000_0000, 120);
        run_compare("soft_release_restart", 120, -1, 4'h0, 32'h0, 1 << 30);

        // Integer period of 4, then disable while high.
        start_engine(32'd4, 32'h0);
        build_model(64'd4, 64'd0, 44);
        run_compare("int4_then_disable", 44, 38, 4'h4, 32'h0, 38);

        // Period length change lands only at the next period boundary.
        start_engine(32'd10, 32'h0);
        exp_q.delete();
        exp_q.push_back(1'b0);
        push_period(10);
        while (exp_q.size() < 40) push_period(6);
        run_compare("mid_period_change", 40, 4, 4'h8, 32'd6, 1 << 30);

        // INT=1 with carries: alternating P=1 (low) and P=2 (one high, one low).
        start_engine(32'd1, 32'h8000_0000);
        build_model(64'd1, 64'h8000_0000, 30);
        run_compare("int1_carry", 30, -1, 4'h0, 32'h0, 1 << 30);

        for (int t = 0; t < 6; t++) begin
            logic [31:0] int_v, frac_v;
            int_v  = 32'($urandom_range(2, 30));
            frac_v = $urandom;
            csr_write(4'h4, 32'h0, 4'hF);
            csr_write(4'h8, int_v, 4'hF);
            csr_write(4'hC, frac_v, 4'hF);
            csr_read(4'h8, rint);
            csr_read(4'hC, rfrac);
            check("rand_int_rb", {32'd0, rint}, {32'd0, int_v});
            check("rand_frac_rb", {32'd0, rfrac}, {32'd0, frac_v});
            csr_write(4'h4, 32'h1, 4'hF);
            build_model(64'(int_v), 64'(frac_v), 150);
            run_compare($sformatf("rand_trial%0d_int%0d_frac%h", t, int_v, frac_v), 150, -1, 4'h0, 32'h0, 1 << 30);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
